// File: rtl/cnt_sched_ift.sv
// -----------------------------------------------------------------------------
// cnt_sched_ift
//
// Round-robin scheduler that shares one external 4-bit up-counter between
// N_REQ requesters. A granted requester gets an optional one-cycle counter
// clear followed by a burst of `len` counter enables, then a one-cycle `done`
// pulse. Implicit-flow taint is tracked for all control outputs: they are all
// decoded from registered state, so they share one taint register (st_t).
//
// Ports
//   clk      in   1              clock, all logic on posedge
//   clk_t    in   TAINT_W        clock taint, accepted and unused
//   rst      in   1              synchronous active-high reset
//   rst_t    in   TAINT_W        reset taint
//   req      in   N_REQ          request per requester, held until its done
//   req_t    in   N_REQ*TAINT_W  taint per req bit
//   len      in   N_REQ*LEN_W    increments requested per requester
//   len_t    in   N_REQ*TAINT_W  taint per len slice
//   clr      in   N_REQ          clear counter before the burst
//   gnt      out  N_REQ          one-hot grant, held for the transaction
//   done     out  N_REQ          one-cycle completion pulse
//   busy     out  1              high in any state other than IDLE
//   cnt_rst  out  1              drives the counter's rst
//   cnt_en   out  1              drives the counter's en
//   ctl_t    out  TAINT_W        shared taint of all control outputs
//
// Configuration
//   CNT_SCHED_TAINT_STICKY_EN  defined: st_t accumulates across transactions
//                              and clears only on rst.
//                              undefined: st_t is reloaded at every grant from
//                              the rst_t captured at the last reset.
// -----------------------------------------------------------------------------
module cnt_sched_ift #(
    parameter int N_REQ   = 4,
    parameter int LEN_W   = 4,
    parameter int TAINT_W = 32
) (
    input  logic                     clk,
    input  logic [TAINT_W-1:0]       clk_t,
    input  logic                     rst,
    input  logic [TAINT_W-1:0]       rst_t,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*TAINT_W-1:0] req_t,
    input  logic [N_REQ*LEN_W-1:0]   len,
    input  logic [N_REQ*TAINT_W-1:0] len_t,
    input  logic [N_REQ-1:0]         clr,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic                     cnt_rst,
    output logic                     cnt_en,
    output logic [TAINT_W-1:0]       ctl_t
);

    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [LEN_W-1:0]   r_rem;
    // Taint starts clean in simulation until the first reset loads rst_t.
    logic [TAINT_W-1:0] r_st_t = '0;

    // -------------------------------------------------------------------------
    // Unpacked views of the flat per-requester buses
    // -------------------------------------------------------------------------
    logic [LEN_W-1:0]   w_len   [N_REQ];
    logic [TAINT_W-1:0] w_req_t [N_REQ];
    logic [TAINT_W-1:0] w_len_t [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_len[g]   = len[g*LEN_W +: LEN_W];
        assign w_req_t[g] = req_t[g*TAINT_W +: TAINT_W];
        assign w_len_t[g] = len_t[g*TAINT_W +: TAINT_W];
    end

    // Clock taint has no path into this design.
    logic w_unused_clk_t;
    assign w_unused_clk_t = ^clk_t;

    // -------------------------------------------------------------------------
    // Round-robin search
    // The winner is the lowest set request at or above ptr; if there is none,
    // the search wraps and the lowest set request overall wins.
    // -------------------------------------------------------------------------
    logic             w_found;
    logic             w_hit_hi;
    logic [SEL_W-1:0] w_pick_hi;
    logic [SEL_W-1:0] w_pick_lo;
    logic [SEL_W-1:0] w_pick;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_hit_hi  = 1'b0;
        w_pick_hi = '0;
        w_pick_lo = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_pick_lo = SEL_W'(i);
                if (SEL_W'(i) >= r_ptr) begin
                    w_hit_hi  = 1'b1;
                    w_pick_hi = SEL_W'(i);
                end
            end
        end
        w_found = |req;
        w_pick  = w_hit_hi ? w_pick_hi : w_pick_lo;
    end

    // -------------------------------------------------------------------------
    // Grant-time taint: arbitration depends on every request line, the burst
    // length of the winner and, when it clears, on its request as well.
    // -------------------------------------------------------------------------
    logic [TAINT_W-1:0] w_req_t_any;
    logic [TAINT_W-1:0] w_grant_t;
    logic [TAINT_W-1:0] w_base_t;

    always_comb begin
        w_req_t_any = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_req_t_any = w_req_t_any | w_req_t[i];
        end
    end

    assign w_grant_t = w_req_t_any | w_len_t[w_pick]
                     | (clr[w_pick] ? w_req_t[w_pick] : '0);

`ifdef CNT_SCHED_TAINT_STICKY_EN
    // Taint keeps accumulating across transactions.
    assign w_base_t = r_st_t;
`else
    // Taint restarts from the reset taint at every grant.
    logic [TAINT_W-1:0] r_rst_t = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_t <= rst_t;
        end
    end

    assign w_base_t = r_rst_t;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and Moore outputs
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] w_sel_oh;
    assign w_sel_oh = N_REQ'(1) << r_sel;

    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        done        = '0;
        busy        = 1'b0;
        cnt_rst     = 1'b0;
        cnt_en      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    if (clr[w_pick]) begin
                        w_state_nxt = S_CLEAR;
                    end else if (w_len[w_pick] != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_CLEAR: begin
                gnt     = w_sel_oh;
                busy    = 1'b1;
                cnt_rst = 1'b1;
                w_state_nxt = (r_rem != '0) ? S_RUN : S_DONE;
            end

            S_RUN: begin
                gnt    = w_sel_oh;
                busy   = 1'b1;
                cnt_en = 1'b1;
                // The last increment and an abort both still enable the
                // counter in this cycle.
                if ((r_rem == LEN_W'(1)) || !req[r_sel]) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                gnt  = w_sel_oh;
                done = w_sel_oh;
                busy = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: selection, remaining count, pointer, taint
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= '0;
            r_ptr  <= '0;
            r_rem  <= '0;
            r_st_t <= rst_t;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel  <= w_pick;
                        r_rem  <= w_len[w_pick];
                        r_st_t <= w_base_t | w_grant_t;
                    end
                end

                S_RUN: begin
                    r_rem  <= r_rem - LEN_W'(1);
                    // Staying in RUN depends on the granted request line.
                    r_st_t <= r_st_t | w_req_t[r_sel];
                end

                S_DONE: begin
                    r_ptr <= (r_sel == SEL_W'(N_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
                end

                default: begin
                end
            endcase
        end
    end

    assign ctl_t = r_st_t;

endmodule

// File: tb/tb_cnt_sched_ift.sv
// -----------------------------------------------------------------------------
// tb_cnt_sched_ift
//
// Directed and randomized transactions against cnt_sched_ift. A transaction
// level reference model (round-robin winner, clear/run/done timeline, taint
// accumulation) predicts every output cycle by cycle. An emulated external
// counter is driven from the DUT's cnt_rst/cnt_en outputs.
// -----------------------------------------------------------------------------
module tb_cnt_sched_ift;

    localparam int N_REQ   = 4;
    localparam int LEN_W   = 4;
    localparam int TAINT_W = 32;

    logic                     clk = 1'b0;
    logic [TAINT_W-1:0]       clk_t;
    logic                     rst;
    logic [TAINT_W-1:0]       rst_t;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*TAINT_W-1:0] req_t;
    logic [N_REQ*LEN_W-1:0]   len;
    logic [N_REQ*TAINT_W-1:0] len_t;
    logic [N_REQ-1:0]         clr;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         done;
    logic                     busy;
    logic                     cnt_rst;
    logic                     cnt_en;
    logic [TAINT_W-1:0]       ctl_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int                 m_ptr = 0;
    logic [TAINT_W-1:0] m_st  = '0;
    logic [TAINT_W-1:0] m_rst = '0;

    // External 4-bit counter driven by the scheduler
    int ext_cnt = 0;

    cnt_sched_ift #(
        .N_REQ  (N_REQ),
        .LEN_W  (LEN_W),
        .TAINT_W(TAINT_W)
    ) dut (
        .clk    (clk),
        .clk_t  (clk_t),
        .rst    (rst),
        .rst_t  (rst_t),
        .req    (req),
        .req_t  (req_t),
        .len    (len),
        .len_t  (len_t),
        .clr    (clr),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt_rst(cnt_rst),
        .cnt_en (cnt_en),
        .ctl_t  (ctl_t)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cnt_rst) begin
            ext_cnt <= 0;
        end else if (cnt_en) begin
            ext_cnt <= (ext_cnt + 1) % 16;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_ctl();
        return 32'({gnt, done, busy, cnt_rst, cnt_en});
    endfunction

    function automatic logic [31:0] exp_ctl(input int sel, input bit g, input bit d,
                                            input bit cr, input bit ce);
        logic [N_REQ-1:0] oh;
        oh = N_REQ'(1) << sel;
        return 32'({(g ? oh : 4'b0000), (d ? oh : 4'b0000), g, cr, ce});
    endfunction

    function automatic int first_req(input logic [N_REQ-1:0] r, input int p);
        for (int i = 0; i < N_REQ; i++) begin
            if (r[(p + i) % N_REQ]) return (p + i) % N_REQ;
        end
        return -1;
    endfunction

    task automatic do_reset(input logic [TAINT_W-1:0] t);
        rst   = 1'b1;
        rst_t = t;
        step();
        chk("reset_outputs", obs_ctl(), 32'h0);
        chk("reset_ctl_t", ctl_t, t);
        rst   = 1'b0;
        rst_t = $urandom;
        m_ptr = 0;
        m_st  = t;
        m_rst = t;
    endtask

    // Called in an IDLE cycle with the inputs set up; runs one transaction
    // through to the following IDLE cycle. n_abort > 0 drops the winner's
    // request in that RUN cycle.
    task automatic run_txn(input int n_abort, input bit release_req,
                           output int w, output logic [N_REQ-1:0] g_seen);
        int                 l;
        bit                 c;
        int                 n_run;
        logic [TAINT_W-1:0] st;
        logic [TAINT_W-1:0] any_t;

        g_seen = '0;
        w = first_req(req, m_ptr);
        if (w < 0) begin
            chk("txn_has_request", 32'(req), 32'h1);
            return;
        end
        l = int'(len[w*LEN_W +: LEN_W]);
        c = clr[w];
        any_t = '0;
        for (int i = 0; i < N_REQ; i++) any_t = any_t | req_t[i*TAINT_W +: TAINT_W];
`ifdef CNT_SCHED_TAINT_STICKY_EN
        st = m_st;
`else
        st = m_rst;
`endif
        st = st | any_t | len_t[w*TAINT_W +: TAINT_W]
           | (c ? req_t[w*TAINT_W +: TAINT_W] : '0);
        n_run = (n_abort > 0 && n_abort < l) ? n_abort : l;

        step();
        g_seen = gnt;
        if (c) begin
            chk("clear_cycle", obs_ctl(), exp_ctl(w, 1, 0, 1, 0));
            chk("clear_ctl_t", ctl_t, st);
            step();
        end
        for (int k = 1; k <= n_run; k++) begin
            chk("run_cycle", obs_ctl(), exp_ctl(w, 1, 0, 0, 1));
            chk("run_ctl_t", ctl_t, st);
            st = st | req_t[w*TAINT_W +: TAINT_W];
            if (k == n_abort) req[w] = 1'b0;
            step();
        end
        chk("done_cycle", obs_ctl(), exp_ctl(w, 1, 1, 0, 0));
        chk("done_ctl_t", ctl_t, st);
        if (release_req) req[w] = 1'b0;
        m_ptr = (w + 1) % N_REQ;
        m_st  = st;
        step();
        chk("idle_after_done", obs_ctl(), 32'h0);
    endtask

    initial begin
        int               w;
        int               cnt0;
        logic [N_REQ-1:0] gs;
        int               fair_order [5];

        fair_order = '{0, 1, 2, 3, 0};
        clk_t = 32'hDEAD_BEEF;
        rst   = 1'b1;
        rst_t = '0;
        req   = '0;
        req_t = '0;
        len   = '0;
        len_t = '0;
        clr   = '0;

        // Single burst
        do_reset(32'h1);
        req = 4'b0001;
        len[0*LEN_W +: LEN_W] = 4'd3;
        cnt0 = ext_cnt;
        run_txn(0, 1, w, gs);
        chk("single_counter", 32'((ext_cnt - cnt0 + 16) % 16), 32'd3);
        chk("single_ctl_t", ctl_t, 32'h1);

        // Clear plus burst
        req = 4'b0010;
        len[1*LEN_W +: LEN_W] = 4'd2;
        clr[1] = 1'b1;
        req_t[1*TAINT_W +: TAINT_W] = 32'h4;
        run_txn(0, 1, w, gs);
        chk("clear_counter", 32'(ext_cnt), 32'd2);
        req_t = '0;
        clr   = '0;

        // Fairness with all requests held
        do_reset(32'h0);
        for (int i = 0; i < N_REQ; i++) len[i*LEN_W +: LEN_W] = 4'd1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 0, w, gs);
            chk("fair_order", 32'(gs), 32'(N_REQ'(1) << fair_order[i]));
        end
        req = '0;

        // Zero length, then abort after 4 RUN cycles of a 10-long burst
        req = 4'b0100;
        len[2*LEN_W +: LEN_W] = 4'd0;
        run_txn(0, 1, w, gs);
        req = 4'b1000;
        len[3*LEN_W +: LEN_W] = 4'd10;
        cnt0 = ext_cnt;
        run_txn(4, 1, w, gs);
        chk("abort_enables", 32'((ext_cnt - cnt0 + 16) % 16), 32'd4);

        // Move ptr to 2, then reset in the middle of a RUN
        req = 4'b0010;
        len[1*LEN_W +: LEN_W] = 4'd0;
        run_txn(0, 1, w, gs);
        req = 4'b0100;
        len[2*LEN_W +: LEN_W] = 4'd8;
        step();
        chk("mid_run_enable", obs_ctl(), exp_ctl(2, 1, 0, 0, 1));
        step();
        step();
        do_reset(32'h2);
        req = 4'b1010;
        len[1*LEN_W +: LEN_W] = 4'd1;
        len[3*LEN_W +: LEN_W] = 4'd1;
        run_txn(0, 1, w, gs);
        chk("ptr_after_reset", 32'(gs), 32'h2);
        req = 4'b0100;
        len[2*LEN_W +: LEN_W] = 4'd2;
        run_txn(0, 1, w, gs);
        chk("grant_after_reset", 32'(gs), 32'h4);
        req = '0;

        // Taint carry-over between transactions
        do_reset(32'h0);
        req = 4'b0001;
        len[0*LEN_W +: LEN_W] = 4'd1;
        len_t[0*TAINT_W +: TAINT_W] = 32'h10;
        run_txn(0, 1, w, gs);
        req = 4'b0001;
        len_t = '0;
        run_txn(0, 1, w, gs);
`ifdef CNT_SCHED_TAINT_STICKY_EN
        chk("sticky_bit4", 32'(ctl_t[4]), 32'h1);
`else
        chk("reload_bit4", 32'(ctl_t[4]), 32'h0);
`endif

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            int ab;
            if (t % 15 == 14) do_reset(32'h1 << $urandom_range(0, 31));
            req = N_REQ'($urandom_range(1, 15));
            clr = N_REQ'($urandom_range(0, 15));
            for (int i = 0; i < N_REQ; i++) begin
                len[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 15));
                req_t[i*TAINT_W +: TAINT_W] =
                    ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
                len_t[i*TAINT_W +: TAINT_W] =
                    ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            end
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            run_txn(ab, 1'($urandom_range(0, 1)), w, gs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cnt_sched_ift.md
# cnt_sched_ift

- Round-robin scheduler that shares one counter datapath (4-bit up-counter with `rst`/`en` inputs and 32-bit taint shadows) between several requesters.
- Each requester asks for a burst of increments, optionally preceded by a clear. The scheduler grants one requester at a time and drives the counter's clear and enable lines.
- Implicit-flow taint is tracked for every control output, so the instrumented IFT design carries taint from requesters through arbitration into the counter.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters.
- `LEN_W`, 4: width of each burst-length field.
- `TAINT_W`, 32: width of each taint vector.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `clk_t`  in  TAINT_W  clock taint; accepted and unused.
- `rst`  in  1  synchronous, active-high reset.
- `rst_t`  in  TAINT_W  reset taint.
- `req`  in  N_REQ  request per requester; held until its `done`.
- `req_t`  in  N_REQ*TAINT_W  taint per `req` bit; slice i is `[i*TAINT_W +: TAINT_W]`.
- `len`  in  N_REQ*LEN_W  increments requested; slice i is `[i*LEN_W +: LEN_W]`.
- `len_t`  in  N_REQ*TAINT_W  taint per `len` slice.
- `clr`  in  N_REQ  clear counter before the burst.
- `gnt`  out  N_REQ  one-hot grant, held for the whole transaction.
- `done`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `busy`  out  1  high in any state other than IDLE.
- `cnt_rst`  out  1  drives the counter's `rst`.
- `cnt_en`  out  1  drives the counter's `en`.
- `ctl_t`  out  TAINT_W  taint of `gnt`, `done`, `busy`, `cnt_rst` and `cnt_en`; all are state-derived, so they share one taint.

## Operation

- **States:** IDLE, CLEAR, RUN, DONE.
- **Registers:** state, `sel` (granted index), `rem` (LEN_W remaining count), `ptr` (round-robin pointer), `st_t` (state taint).
- **IDLE:**
  - Search `req` starting at `ptr`, wrapping modulo N_REQ. The first set bit becomes `sel`.
  - Latch `rem <= len[sel]`.
  - Next state: CLEAR if `clr[sel]`; else RUN if `len[sel] != 0`; else DONE.
  - No request: stay in IDLE.
- **CLEAR:**
  - `cnt_rst = 1` for exactly one cycle.
  - Next state: RUN if `rem != 0`, else DONE.
- **RUN:**
  - `cnt_en = 1` each cycle and `rem` decrements.
  - When `rem == 1`, go to DONE.
  - Abort: if `req[sel]` is low in any RUN cycle, go to DONE next. `cnt_en` is still high in that observed cycle.
- **DONE:**
  - `done[sel] = 1` for one cycle.
  - `ptr <= (sel + 1) mod N_REQ`.
  - Next state: IDLE.
- **Grant:** `gnt[sel] = 1` in CLEAR, RUN and DONE; 0 in IDLE.
- **Outputs:** all are Moore outputs decoded from registered state; no combinational path from `req` to any output.
- **Length arithmetic:** `len` is unsigned. The maximum, 2^LEN_W−1, gives 15 enables. The counter itself wraps modulo 16; that wrap is the counter's concern, not the scheduler's.
- **Taint update:** `st_t` is a register and `ctl_t = st_t`.
  - On `rst`: `st_t <= rst_t`. Simulation-initial value is 0.
  - At grant (IDLE → next state): `st_t <= st_t | (OR of all N_REQ req_t slices) | len_t[sel] | (clr[sel] ? req_t[sel] : 0)`. Arbitration outcome depends on every request line.
  - Each RUN cycle: `st_t <= st_t | req_t[sel]`, covering the abort dependency.
- **Reset mid-transaction:**
  - State goes to IDLE next cycle; `gnt`, `cnt_en` and `cnt_rst` drop; no `done` pulse.
  - `ptr` is reset to 0.

## Timing

- **Reset values:** state IDLE, `ptr` 0, `sel` 0, `rem` 0, and all outputs 0 (`gnt`, `done`, `busy`, `cnt_rst`, `cnt_en`). `ctl_t` equals the `rst_t` sampled at reset.
- **Grant latency:** `req` sampled in IDLE at edge k → `gnt`/`busy` high from cycle k+1.
- **Transaction length:** `clr` (1 cycle if set) + `len` RUN cycles + 1 DONE cycle.
- **Back-to-back:** at least one IDLE cycle between transactions; the next grant comes no earlier than 2 cycles after `done`.
- **Simultaneous requests:** resolved purely by `ptr`. A requester waits at most N_REQ−1 transactions.
- **`rst` priority:** `rst` overrides every other input in the same cycle.

## Configuration

- **`CNT_SCHED_TAINT_STICKY_EN` defined:** `st_t` accumulates (OR) across transactions and clears only on `rst`.
- **Undefined:** at each grant, `st_t` is reloaded rather than ORed: `st_t <= rst_t_reg | OR req_t | len_t[sel] | (clr ? req_t[sel] : 0)`.
  - `rst_t_reg` holds the `rst_t` captured at the last reset.
  - RUN-cycle accumulation is unchanged.

## Test plan

- **Single burst:** reset with `rst_t = 0x1`; `req = 0001`, `len[0] = 3`, `clr[0] = 0`, all other taint 0 → `cnt_en` high for exactly 3 cycles, then `done[0]`; `ctl_t = 0x1`; external counter reads 3.
- **Clear plus burst:** `req = 0010`, `len[1] = 2`, `clr[1] = 1`, `req_t[1] = 0x4` → one `cnt_rst` cycle, then 2 enables; counter reads 2; `ctl_t` includes `0x4` from cycle k+1 onward.
- **Fairness:** `req = 1111` held, all `len = 1` → grants in order 0, 1, 2, 3, 0; each `done` precedes the next `gnt` by 2 cycles.
- **Abort and zero length:** `len[2] = 0` → no `cnt_en`, `done[2]` two cycles after the request. `len[3] = 10` with `req[3]` dropped after 4 RUN cycles → exactly 4 enables (the abort cycle included), then `done[3]`.
- **Reset mid-RUN:** `rst` asserted during RUN → next cycle all outputs are 0, no `done`, `ptr` is 0; then `req = 0100` → grant 2.
- **Macro check:** `len_t[0] = 0x10` on transaction 1 and 0 on transaction 2 → with `CNT_SCHED_TAINT_STICKY_EN`, `ctl_t` keeps bit 4 during transaction 2; without it, bit 4 is cleared at the second grant.
